uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Parametrised UART transmitter: buffered, runtime-configurable serialiser for the APB_UART TX path.
//  Holds a FIFO_DEPTH-entry TX FIFO written via valid/ready. Bit rate comes from an external baud_en tick.
//  Data length (5..DATA_WIDTH), parity mode, 1/2 stop bits and line break are selected at run time.
//  Sits between the APB register block (writes TXDATA, drives cfg_*) and the tx pad.
// PARAMETERS
//  DATA_WIDTH  9  max data bits per frame; legal 5..9; FIFO entry width
//  FIFO_DEPTH  8  TX FIFO entries; power of 2, >=2
//  LVL_W       $clog2(FIFO_DEPTH+1)  derived localparam, width of fifo_level
// PORTS
//  clk              in   1           system clock
//  rst              in   1           asynchronous reset, active-high
//  baud_en          in   1           one-cycle bit-rate tick
//  wr_data          in   DATA_WIDTH  word to transmit, LSB-aligned
//  wr_valid         in   1           push request
//  wr_ready         out  1           FIFO can accept (= !fifo_full)
//  flush            in   1           clear FIFO contents (sync pulse)
//  cfg_data_bits    in   4           data bits per frame, 5..DATA_WIDTH
//  cfg_parity_en    in   1           1: insert parity bit
//  cfg_parity_mode  in   2           00 even, 01 odd, 10 mark(1), 11 space(0)
//  cfg_stop2        in   1           0: one stop bit, 1: two stop bits
//  brk_req          in   1           level: hold line low (break) between frames
//  tx               out  1           serial line, idle high
//  tx_busy          out  1           FSM not IDLE (frame or break in progress)
//  frame_done       out  1           one-cycle pulse when last stop bit is driven
//  fifo_level       out  LVL_W       entries held
//  fifo_empty       out  1           fifo_level == 0
//  fifo_full        out  1           fifo_level == FIFO_DEPTH
// BEHAVIOUR
//  Reset (async, rst=1): tx=1, tx_busy=0, frame_done=0, FIFO empty, level=0, wr_ready=1, FSM IDLE; any frame is aborted.
//  FIFO: push when wr_valid&&wr_ready; pop only by FSM, only when non-empty.
//   - Push at full: refused; pop in the same cycle does not make room.
//   - Push into empty: no same-cycle pop; the word pops the following cycle.
//   - Push+pop when neither full nor empty: level unchanged.
//   - flush: level->0 next cycle, same-cycle push discarded; an in-flight frame completes.
//   - Pointers wrap modulo FIFO_DEPTH.
//  FSM states: IDLE, START, DATA, PARITY, STOP, BREAK. The tx output changes only on baud_en cycles (except reset).
//  IDLE -> BREAK: brk_req=1 has priority over a non-empty FIFO.
//  IDLE -> START: when the FIFO is non-empty, pop and enter START on the same cycle.
//   - The popped word goes into the shift register.
//   - cfg_* are latched; later cfg changes affect only the next frame.
//   - tx_busy=1 from the next cycle.
//  START: on baud_en, tx<=0; bit_cnt<=0; -> DATA.
//  DATA: on each baud_en, tx<=data[bit_cnt], LSB first.
//   - After bit cfg_data_bits-1: go to PARITY if parity is enabled, else STOP.
//  PARITY: on baud_en, tx<= even: ^data[n-1:0]; odd: ~^data[n-1:0]; mark 1; space 0. Bits above n are ignored. -> STOP.
//  STOP: on baud_en, tx<=1.
//   - Repeat for 2 ticks if cfg_stop2.
//   - On the final stop tick: frame_done=1 for that cycle, -> IDLE, tx_busy<=0.
//  Back-to-back frames: the next pop happens in the cycle after STOP exits.
//   - Its start bit is driven at the next baud_en, so each stop bit lasts one full baud period.
//  BREAK: on baud_en, tx<=0 while brk_req=1.
//   - After brk_req=0: on the next baud_en, tx<=1 and -> IDLE.
//   - The FIFO is not popped during BREAK. brk_req raised mid-frame waits for frame end.
//  Illegal cfg_data_bits (<5 or >DATA_WIDTH) is clamped to the nearest legal value when latched.
// TESTING
//  8N1, push 0xA5 -> tx ticks: 0,1,0,1,0,0,1,0,1,1 (start, LSB-first, stop); frame_done once; busy low after.
//  7E2, push 0x53 (bits 1010011... n=7 -> 0x53) -> 7 data bits, parity 0, two high stop ticks.
//  Odd/mark/space with 8 bits: 0x00 -> parity 1/1/0.
//  Push 9 words at DEPTH=8 with baud_en off -> 8 accepted, wr_ready=0, level=8.
//   - Enable baud: 8 contiguous frames, no idle ticks between frames.
//  brk_req=1 during a frame -> frame finishes first, then tx low.
//   - Release -> tx high at the next tick; queued word sent afterwards.
//  Reset asserted mid-DATA -> tx=1 immediately, level=0.
//   - After release: an idle line until a new push.
//  Simultaneous push+pop at level=3 keeps level 3.
//  flush mid-frame -> current frame completes, nothing further sent.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: TX FIFO feeding a runtime-configurable start/data/parity/stop serialiser.
// Bit timing comes from an external baud_en tick; wr_ready drops only while the FIFO is full.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 9,
    parameter int FIFO_DEPTH = 8,
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  baud_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  flush,
    input  logic [3:0]            cfg_data_bits,
    input  logic                  cfg_parity_en,
    input  logic [1:0]            cfg_parity_mode,
    input  logic                  cfg_stop2,
    input  logic                  brk_req,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  frame_done,
    output logic [LVL_W-1:0]      fifo_level,
    output logic                  fifo_empty,
    output logic                  fifo_full
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [3:0] DW4 = 4'(DATA_WIDTH);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] BREAK  = 3'd5;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  push, pop;

    logic [2:0]            state_q, state_d;
    logic                  tx_q, tx_d;
    logic                  frame_done_q, frame_done_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [3:0]            n_q, n_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  par_q, par_d;
    logic                  stop2_q, stop2_d;
    logic                  stop_cnt_q, stop_cnt_d;

    logic [DATA_WIDTH-1:0] head;
    logic [3:0]            n_clamp;
    logic                  head_xor;
    logic                  par_bit;

    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (level_q == '0);
    assign fifo_level = level_q;
    assign wr_ready   = !fifo_full;
    assign push       = wr_valid && wr_ready && !flush;
    assign head       = mem_q[rd_ptr_q];

    assign tx         = tx_q;
    assign tx_busy    = (state_q != IDLE);
    assign frame_done = frame_done_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Length is clamped and parity precomputed at pop, so the frame is immune to later cfg changes.
    always_comb begin
        if (cfg_data_bits < 4'd5)      n_clamp = 4'd5;
        else if (cfg_data_bits > DW4)  n_clamp = DW4;
        else                           n_clamp = cfg_data_bits;
        head_xor = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i < int'(n_clamp)) head_xor = head_xor ^ head[i];
        end
        case (cfg_parity_mode)
            2'b00:   par_bit = head_xor;
            2'b01:   par_bit = ~head_xor;
            2'b10:   par_bit = 1'b1;
            default: par_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        tx_d         = tx_q;
        frame_done_d = 1'b0;
        data_d       = data_q;
        n_d          = n_q;
        bit_cnt_d    = bit_cnt_q;
        par_en_d     = par_en_q;
        par_d        = par_q;
        stop2_d      = stop2_q;
        stop_cnt_d   = stop_cnt_q;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                if (brk_req) begin
                    state_d = BREAK;
                end else if (!fifo_empty && !flush) begin
                    pop      = 1'b1;
                    data_d   = head;
                    n_d      = n_clamp;
                    par_en_d = cfg_parity_en;
                    par_d    = par_bit;
                    stop2_d  = cfg_stop2;
                    state_d  = START;
                end
            end
            START: if (baud_en) begin
                tx_d      = 1'b0;
                bit_cnt_d = 4'd0;
                state_d   = DATA;
            end
            DATA: if (baud_en) begin
                tx_d      = data_q[0];
                data_d    = data_q >> 1;
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == n_q - 4'd1) begin
                    stop_cnt_d = 1'b0;
                    state_d    = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: if (baud_en) begin
                tx_d    = par_q;
                state_d = STOP;
            end
            STOP: if (baud_en) begin
                tx_d = 1'b1;
                if (stop2_q && !stop_cnt_q) begin
                    stop_cnt_d = 1'b1;
                end else begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            BREAK: if (baud_en) begin
                if (brk_req) begin
                    tx_d = 1'b0;
                end else begin
                    tx_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            state_q      <= IDLE;
            tx_q         <= 1'b1;
            frame_done_q <= 1'b0;
            data_q       <= '0;
            n_q          <= 4'd8;
            bit_cnt_q    <= 4'd0;
            par_en_q     <= 1'b0;
            par_q        <= 1'b0;
            stop2_q      <= 1'b0;
            stop_cnt_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            state_q      <= state_d;
            tx_q         <= tx_d;
            frame_done_q <= frame_done_d;
            data_q       <= data_d;
            n_q          <= n_d;
            bit_cnt_q    <= bit_cnt_d;
            par_en_q     <= par_en_d;
            par_q        <= par_d;
            stop2_q      <= stop2_d;
            stop_cnt_q   <= stop_cnt_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frames, parity modes, FIFO fill, break, flush, mid-frame reset.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_en = 1'b0;
    logic [8:0] wr_data = '0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic       flush = 1'b0;
    logic [3:0] cfg_data_bits = 4'd8;
    logic       cfg_parity_en = 1'b0;
    logic [1:0] cfg_parity_mode = 2'b00;
    logic       cfg_stop2 = 1'b0;
    logic       brk_req = 1'b0;
    logic       tx, tx_busy, frame_done, fifo_empty, fifo_full;
    logic [3:0] fifo_level;

    int tests = 0;
    int fails = 0;

    uart_tx_fifo #(.DATA_WIDTH(9), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .baud_en(baud_en), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .flush(flush), .cfg_data_bits(cfg_data_bits),
        .cfg_parity_en(cfg_parity_en), .cfg_parity_mode(cfg_parity_mode), .cfg_stop2(cfg_stop2),
        .brk_req(brk_req), .tx(tx), .tx_busy(tx_busy), .frame_done(frame_done),
        .fifo_level(fifo_level), .fifo_empty(fifo_empty), .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(output logic t, output logic fd);
        @(negedge clk); baud_en = 1'b1;
        @(negedge clk); baud_en = 1'b0;
        t  = tx;
        fd = frame_done;
    endtask

    task automatic run_ticks(input int n, output logic [15:0] seq, output int fdc, output logic last_fd);
        logic t, fd;
        seq = '0; fdc = 0; last_fd = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick(t, fd);
            seq = {seq[14:0], t};
            if (fd) fdc++;
            last_fd = fd;
        end
    endtask

    task automatic push(input logic [8:0] d, output logic acc);
        @(negedge clk); wr_valid = 1'b1; wr_data = d; acc = wr_ready;
        @(negedge clk); wr_valid = 1'b0;
    endtask

    // Expected 8N1 line sequence, first tick in the MSB.
    function automatic logic [9:0] f8n1(input logic [7:0] d);
        logic [9:0] s;
        s[9] = 1'b0;
        for (int i = 0; i < 8; i++) s[8-i] = d[i];
        s[0] = 1'b1;
        return s;
    endfunction

    logic [15:0] seq, seq2;
    int          fdc;
    logic        lfd, acc, t, fd;
    int          nacc;
    logic [9:0]  ef;
    logic [1:0]  pmode [3] = '{2'b01, 2'b10, 2'b11};
    logic        pexp  [3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0]  fillw [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_tx", 32'(tx), 1);
        chk("rst_busy", 32'(tx_busy), 0);
        chk("rst_fd", 32'(frame_done), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_empty", 32'(fifo_empty), 1);
        chk("rst_wr_ready", 32'(wr_ready), 1);
        rst = 1'b0;

        // 8N1 0xA5
        push(9'h0A5, acc);
        run_ticks(10, seq, fdc, lfd);
        chk("8n1_seq", 32'(seq[9:0]), 32'b0101001011);
        chk("8n1_fd_cnt", 32'(fdc), 1);
        chk("8n1_fd_last", 32'(lfd), 1);
        chk("8n1_busy_after", 32'(tx_busy), 0);

        // 7E2 0x53; cfg changed after the pop must not affect this frame
        cfg_data_bits = 4'd7; cfg_parity_en = 1'b1; cfg_parity_mode = 2'b00; cfg_stop2 = 1'b1;
        push(9'h053, acc);
        @(negedge clk);
        chk("7e2_busy", 32'(tx_busy), 1);
        cfg_data_bits = 4'd8; cfg_stop2 = 1'b0; cfg_parity_en = 1'b0;
        run_ticks(11, seq, fdc, lfd);
        chk("7e2_seq", 32'(seq[10:0]), 32'b01100101011);
        chk("7e2_fd_last", 32'(lfd), 1);
        chk("7e2_fd_cnt", 32'(fdc), 1);

        // odd / mark / space on 0x00, 8 data bits
        for (int m = 0; m < 3; m++) begin
            cfg_data_bits = 4'd8; cfg_parity_en = 1'b1; cfg_parity_mode = pmode[m]; cfg_stop2 = 1'b0;
            push(9'h000, acc);
            run_ticks(11, seq, fdc, lfd);
            chk("par_seq", 32'(seq[10:0]), 32'({1'b0, 8'h00, pexp[m], 1'b1}));
        end

        // data length 3 clamps to 5
        cfg_data_bits = 4'd3; cfg_parity_en = 1'b0;
        push(9'h02A, acc);
        run_ticks(7, seq, fdc, lfd);
        chk("clamp_seq", 32'(seq[6:0]), 32'b0010101);
        chk("clamp_fd_last", 32'(lfd), 1);
        chk("clamp_fd_cnt", 32'(fdc), 1);
        cfg_data_bits = 4'd8;

        // fill while parked in BREAK with no baud ticks
        brk_req = 1'b1;
        repeat (2) @(negedge clk);
        chk("brk_idle_busy", 32'(tx_busy), 1);
        chk("brk_no_tick_tx", 32'(tx), 1);
        nacc = 0;
        for (int i = 0; i < 9; i++) begin
            push({1'b0, (i < 8) ? fillw[i] : 8'hFF}, acc);
            if (acc) nacc++;
        end
        chk("fill_accepted", 32'(nacc), 8);
        chk("fill_level", 32'(fifo_level), 8);
        chk("fill_wr_ready", 32'(wr_ready), 0);
        chk("fill_full", 32'(fifo_full), 1);
        brk_req = 1'b0;
        tick(t, fd);
        chk("brk_exit_tx", 32'(t), 1);
        fdc = 0;
        for (int i = 0; i < 8; i++) begin
            run_ticks(10, seq, nacc, lfd);
            fdc += nacc;
            chk("fill_frame", 32'(seq[9:0]), 32'(f8n1(fillw[i])));
        end
        chk("fill_fd_total", 32'(fdc), 8);
        chk("fill_empty", 32'(fifo_empty), 1);
        chk("fill_busy_end", 32'(tx_busy), 0);

        // break requested mid-frame, then push+pop at level 3, then flush mid-frame
        push(9'h00F, acc);
        run_ticks(3, seq, fdc, lfd);
        brk_req = 1'b1;
        push(9'h03C, acc);
        push(9'h05A, acc);
        push(9'h066, acc);
        run_ticks(7, seq2, fdc, lfd);
        chk("brkmid_frame", 32'({seq[2:0], seq2[6:0]}), 32'(f8n1(8'h0F)));
        chk("brkmid_fd", 32'(lfd), 1);
        tick(t, fd);
        chk("brk_tx_low1", 32'(t), 0);
        chk("brk_level_held", 32'(fifo_level), 3);
        tick(t, fd);
        chk("brk_tx_low2", 32'(t), 0);
        brk_req = 1'b0;
        tick(t, fd);
        chk("brk_release_tx", 32'(t), 1);
        wr_valid = 1'b1; wr_data = 9'h077;
        @(negedge clk); wr_valid = 1'b0;
        chk("pushpop_level", 32'(fifo_level), 3);
        chk("pushpop_busy", 32'(tx_busy), 1);
        ef = f8n1(8'h3C);
        run_ticks(4, seq, fdc, lfd);
        chk("w2_head", 32'(seq[3:0]), 32'(ef[9:6]));
        @(negedge clk); flush = 1'b1; wr_valid = 1'b1; wr_data = 9'h099;
        @(negedge clk); flush = 1'b0; wr_valid = 1'b0;
        chk("flush_level", 32'(fifo_level), 0);
        chk("flush_empty", 32'(fifo_empty), 1);
        run_ticks(6, seq, fdc, lfd);
        chk("w2_tail", 32'(seq[5:0]), 32'(ef[5:0]));
        chk("w2_fd", 32'(lfd), 1);
        run_ticks(4, seq, fdc, lfd);
        chk("post_flush_idle", 32'(seq[3:0]), 32'hF);
        chk("post_flush_fd", 32'(fdc), 0);
        chk("post_flush_busy", 32'(tx_busy), 0);

        // asynchronous reset in the middle of the data bits
        push(9'h055, acc);
        push(9'h033, acc);
        run_ticks(3, seq, fdc, lfd);
        chk("pre_rst_seq", 32'(seq[2:0]), 32'b010);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx", 32'(tx), 1);
        chk("mid_rst_level", 32'(fifo_level), 0);
        chk("mid_rst_busy", 32'(tx_busy), 0);
        @(negedge clk); rst = 1'b0;
        run_ticks(3, seq, fdc, lfd);
        chk("post_rst_idle", 32'(seq[2:0]), 32'b111);
        chk("post_rst_busy", 32'(tx_busy), 0);
        chk("post_rst_fd", 32'(fdc), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
